// File: rtl/btb_pkg.sv
// Shared helpers for the set-associative BTB: tree pseudo-LRU victim/touch functions.
// PLRU trees use heap order: node n has children 2n+1 (lower ways) and 2n+2 (upper ways).
package btb_pkg;

  localparam int PLRU_MAX_W = 7;
  localparam int WAY_MAX_W  = 3;

  function automatic int plru_levels(input int ways);
    return (ways >= 8) ? 3 : (ways >= 4) ? 2 : (ways >= 2) ? 1 : 0;
  endfunction

  function automatic logic [WAY_MAX_W-1:0] plru_victim(input logic [PLRU_MAX_W-1:0] bits,
                                                       input int ways);
    int node;
    int lv;
    node = 0;
    lv   = plru_levels(ways);
    for (int l = 0; l < WAY_MAX_W; l++) begin
      if (l < lv) node = 2 * node + 1 + int'(bits[node[2:0]]);
    end
    return WAY_MAX_W'(node - (ways - 1));
  endfunction

  // Each bit on the path is set to point at the sibling subtree of the touched way.
  function automatic logic [PLRU_MAX_W-1:0] plru_touch(input logic [PLRU_MAX_W-1:0] bits,
                                                       input logic [WAY_MAX_W-1:0] way,
                                                       input int ways);
    logic [PLRU_MAX_W-1:0] r;
    logic [WAY_MAX_W-1:0]  sh;
    int node;
    int lv;
    r    = bits;
    node = 0;
    lv   = plru_levels(ways);
    for (int l = 0; l < WAY_MAX_W; l++) begin
      if (l < lv) begin
        sh = way >> (lv - 1 - l);
        r[node[2:0]] = ~sh[0];
        node = 2 * node + 1 + int'(sh[0]);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/btb_assoc_plru.sv
// Per-set tree pseudo-LRU state; touch A (lookup) is applied before touch B (update),
// so B wins on any shared tree bits. WAYS=1 keeps no state.
module btb_plru
  import btb_pkg::*;
#(
  parameter int WAYS = 2,
  localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             touch_a_en,
  input  logic [WAY_W-1:0] touch_a_way,
  input  logic             touch_b_en,
  input  logic [WAY_W-1:0] touch_b_way,
  output logic [WAY_W-1:0] victim
);

  if (WAYS == 1) begin : g_dm
    logic unused_in;
    assign unused_in = ^{clk, rst, touch_a_en, touch_a_way, touch_b_en, touch_b_way};
    assign victim    = '0;
  end else begin : g_tree
    logic [WAYS-2:0]       bits;
    logic [PLRU_MAX_W-1:0] nxt;
    logic [WAY_MAX_W-1:0]  vic;
    logic                  unused_hi;

    always_comb begin
      nxt = PLRU_MAX_W'(bits);
      if (touch_a_en) nxt = plru_touch(nxt, WAY_MAX_W'(touch_a_way), WAYS);
      if (touch_b_en) nxt = plru_touch(nxt, WAY_MAX_W'(touch_b_way), WAYS);
    end

    always_ff @(posedge clk) begin
      if (rst) bits <= '0;
      else     bits <= nxt[WAYS-2:0];
    end

    assign vic       = plru_victim(PLRU_MAX_W'(bits), WAYS);
    assign victim    = vic[WAY_W-1:0];
    assign unused_hi = ^{vic, nxt};
  end

endmodule

// File: rtl/btb_assoc.sv
// Set-associative BTB with combinational lookup, update-to-lookup bypass, tree PLRU and flush.
// Optional counters (stat_lookups/hits/evictions) built when BTB_ASSOC_STATS_EN is defined.
module btb_assoc
  import btb_pkg::*;
#(
  parameter int PC_W  = 32,
  parameter int IDX_W = 3,
  parameter int WAYS  = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            lk_valid,
  input  logic [PC_W-1:0] lk_pc,
  output logic            lk_hit,
  output logic [PC_W-1:0] lk_target,
  input  logic            upd_valid,
  input  logic [PC_W-1:0] upd_pc,
  input  logic [PC_W-1:0] upd_target
`ifdef BTB_ASSOC_STATS_EN
  ,
  output logic [31:0]     stat_lookups,
  output logic [31:0]     stat_hits,
  output logic [31:0]     stat_evictions
`endif
);

  localparam int TAG_W = PC_W - IDX_W - 2;
  localparam int SETS  = 2 ** IDX_W;
  localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    logic [PC_W-1:0]  target;
  } btb_entry_t;

  btb_entry_t mem [SETS][WAYS];

  logic [IDX_W-1:0] lk_set, upd_set;
  logic [TAG_W-1:0] lk_tag, upd_tag;
  logic             unused_lo;

  assign lk_set    = lk_pc[IDX_W+1:2];
  assign lk_tag    = lk_pc[PC_W-1:IDX_W+2];
  assign upd_set   = upd_pc[IDX_W+1:2];
  assign upd_tag   = upd_pc[PC_W-1:IDX_W+2];
  assign unused_lo = ^{lk_pc[1:0], upd_pc[1:0]};

  logic             arr_hit, bypass;
  logic [WAY_W-1:0] arr_way;
  logic [PC_W-1:0]  arr_tgt;

  always_comb begin
    arr_hit = 1'b0;
    arr_way = '0;
    arr_tgt = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (mem[lk_set][w].valid && mem[lk_set][w].tag == lk_tag) begin
        arr_hit = 1'b1;
        arr_way = WAY_W'(w);
        arr_tgt = mem[lk_set][w].target;
      end
    end
  end

  assign bypass    = upd_valid && upd_set == lk_set && upd_tag == lk_tag;
  assign lk_hit    = !rst && lk_valid && (bypass || arr_hit);
  assign lk_target = !lk_hit ? '0 : (bypass ? upd_target : arr_tgt);

  logic             upd_match, has_inv, evict;
  logic [WAY_W-1:0] match_way, inv_way, upd_way;
  logic [WAY_W-1:0] victims [SETS];

  always_comb begin
    upd_match = 1'b0;
    match_way = '0;
    has_inv   = 1'b0;
    inv_way   = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (mem[upd_set][w].valid && mem[upd_set][w].tag == upd_tag) begin
        upd_match = 1'b1;
        match_way = WAY_W'(w);
      end
      if (!mem[upd_set][w].valid && !has_inv) begin
        has_inv = 1'b1;
        inv_way = WAY_W'(w);
      end
    end
  end

  assign upd_way = upd_match ? match_way : (has_inv ? inv_way : victims[upd_set]);
  assign evict   = upd_valid && !upd_match && !has_inv;

  // A flush-cycle update still lands in storage, but its valid bit follows the flush.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < SETS; s++)
        for (int w = 0; w < WAYS; w++) mem[s][w] <= '0;
    end else begin
      if (flush) begin
        for (int s = 0; s < SETS; s++)
          for (int w = 0; w < WAYS; w++) mem[s][w].valid <= 1'b0;
      end
      if (upd_valid) mem[upd_set][upd_way] <= {!flush, upd_tag, upd_target};
    end
  end

  for (genvar s = 0; s < SETS; s++) begin : g_set
    btb_plru #(.WAYS(WAYS)) u_plru (
      .clk         (clk),
      .rst         (rst),
      .touch_a_en  (lk_valid && arr_hit && lk_set == IDX_W'(s)),
      .touch_a_way (arr_way),
      .touch_b_en  (upd_valid && upd_set == IDX_W'(s)),
      .touch_b_way (upd_way),
      .victim      (victims[s])
    );
  end

`ifdef BTB_ASSOC_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_lookups   <= '0;
      stat_hits      <= '0;
      stat_evictions <= '0;
    end else begin
      if (lk_valid) stat_lookups   <= stat_lookups + 32'd1;
      if (lk_hit)   stat_hits      <= stat_hits + 32'd1;
      if (evict)    stat_evictions <= stat_evictions + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_btb_assoc.sv
// Directed bench for btb_assoc (PC_W=32, IDX_W=3, WAYS=2); pcs 0x100/0x120/0x140/0x160/0x200 share set 0.
module tb_btb_assoc;

  logic        clk = 1'b0;
  logic        rst, flush, lk_valid, upd_valid;
  logic [31:0] lk_pc, upd_pc, upd_target;
  logic        lk_hit;
  logic [31:0] lk_target;
`ifdef BTB_ASSOC_STATS_EN
  logic [31:0] stat_lookups, stat_hits, stat_evictions;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  btb_assoc #(.PC_W(32), .IDX_W(3), .WAYS(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .lk_valid   (lk_valid),
    .lk_pc      (lk_pc),
    .lk_hit     (lk_hit),
    .lk_target  (lk_target),
    .upd_valid  (upd_valid),
    .upd_pc     (upd_pc),
    .upd_target (upd_target)
`ifdef BTB_ASSOC_STATS_EN
    ,
    .stat_lookups   (stat_lookups),
    .stat_hits      (stat_hits),
    .stat_evictions (stat_evictions)
`endif
  );

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", name, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic upd(input logic [31:0] pc, input logic [31:0] tgt);
    upd_valid  = 1'b1;
    upd_pc     = pc;
    upd_target = tgt;
    tick();
    upd_valid  = 1'b0;
  endtask

  // Combinational probe between edges; lk_valid is dropped again before the next edge.
  task automatic look(input string name, input logic [31:0] pc,
                      input logic exp_hit, input logic [31:0] exp_tgt);
    lk_valid = 1'b1;
    lk_pc    = pc;
    #1;
    check({name, "_hit"}, 32'(lk_hit), 32'(exp_hit));
    check({name, "_tgt"}, lk_target, exp_tgt);
    lk_valid = 1'b0;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; lk_valid = 1'b0; upd_valid = 1'b0;
    lk_pc = '0; upd_pc = '0; upd_target = '0;
    tick();
    tick();

    // In reset, even a matching bypass must not report a hit; the update is dropped.
    upd_valid = 1'b1; upd_pc = 32'h100; upd_target = 32'h400;
    look("rst_bypass", 32'h100, 1'b0, 32'h0);
    tick();
    rst = 1'b0; upd_valid = 1'b0;
    look("post_rst", 32'h100, 1'b0, 32'h0);

    // Basic fill and lookup
    upd(32'h100, 32'h400);
    look("fill_100", 32'h100, 1'b1, 32'h400);
    look("miss_104", 32'h104, 1'b0, 32'h0);
    lk_valid = 1'b0; lk_pc = 32'h100;
    #1;
    check("no_valid_hit", 32'(lk_hit), 32'h0);
    check("no_valid_tgt", lk_target, 32'h0);

    // Same-cycle bypass, then the array copy
    upd_valid = 1'b1; upd_pc = 32'h200; upd_target = 32'h800;
    look("bypass_200", 32'h200, 1'b1, 32'h800);
    tick();
    upd_valid = 1'b0;
    look("array_200", 32'h200, 1'b1, 32'h800);

    // PLRU eviction: 0x100->w0, 0x120->w1, touch w0, 0x140 evicts w1 (0x120)
    do_reset();
`ifdef BTB_ASSOC_STATS_EN
    check("stat_evict_rst", stat_evictions, 32'd0);
`endif
    upd(32'h100, 32'h1000);
    upd(32'h120, 32'h1200);
    lk_valid = 1'b1; lk_pc = 32'h100;
    tick();
    lk_valid = 1'b0;
    upd(32'h140, 32'h1400);
    look("lru_100", 32'h100, 1'b1, 32'h1000);
    look("lru_140", 32'h140, 1'b1, 32'h1400);
    look("lru_120", 32'h120, 1'b0, 32'h0);
`ifdef BTB_ASSOC_STATS_EN
    check("stat_evict_1", stat_evictions, 32'd1);
`endif

    // Refresh reuses the matching way; next fill takes the free way, no eviction
    do_reset();
    upd(32'h100, 32'h400);
    upd(32'h100, 32'h500);
    look("refresh_100", 32'h100, 1'b1, 32'h500);
    upd(32'h120, 32'h1200);
    look("fill_120", 32'h120, 1'b1, 32'h1200);
    look("kept_100", 32'h100, 1'b1, 32'h500);
`ifdef BTB_ASSOC_STATS_EN
    check("stat_evict_0", stat_evictions, 32'd0);
`endif

    // Flush with concurrent update; flush-cycle lookup sees old contents
    flush = 1'b1;
    upd_valid = 1'b1; upd_pc = 32'h160; upd_target = 32'h1600;
    look("flush_cycle_100", 32'h100, 1'b1, 32'h500);
    tick();
    flush = 1'b0; upd_valid = 1'b0;
    look("flushed_100", 32'h100, 1'b0, 32'h0);
    look("flushed_120", 32'h120, 1'b0, 32'h0);
    look("flushed_160", 32'h160, 1'b0, 32'h0);

    // Reset during an update: entry must not be written
    upd(32'h200, 32'h800);
    look("pre_rst_200", 32'h200, 1'b1, 32'h800);
    rst = 1'b1;
    upd(32'h240, 32'h900);
    rst = 1'b0;
    look("rst_upd_240", 32'h240, 1'b0, 32'h0);
    look("rst_clr_200", 32'h200, 1'b0, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/btb_assoc.md
Name: btb_assoc

Overview:
- Parametrised set-associative branch target buffer. It succeeds the direct-mapped, data-only BTB storage array.
- Adds per-way tags, valid bits, tree pseudo-LRU replacement, flush, and same-cycle write-to-read bypass.
- Sits in the fetch stage: the PC lookup returns hit and predicted target combinationally; the execute/branch-resolve stage drives updates.

Parameters:
- PC_W, 32, PC and target width.
- IDX_W, 3, set index bits; number of sets = 2**IDX_W.
- WAYS, 2, associativity; power of 2, 1..8; WAYS=1 means direct-mapped with no PLRU state.
- TAG_W (localparam), PC_W-IDX_W-2, tag taken from pc[PC_W-1:IDX_W+2].

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- flush  in  1  clears all valid bits next edge.
- lk_valid  in  1  lookup request this cycle.
- lk_pc  in  PC_W  fetch PC.
- lk_hit  out  1  lookup hit (combinational).
- lk_target  out  PC_W  predicted target; 0 when lk_hit=0.
- upd_valid  in  1  write/refresh request.
- upd_pc  in  PC_W  branch PC.
- upd_target  in  PC_W  resolved target.

Behaviour:
- Set index = pc[IDX_W+1:2]; tag = pc[PC_W-1:IDX_W+2]; pc[1:0] ignored.
- Reset: all valid=0, all PLRU bits=0, all target/tag storage=0. During reset lk_hit=0 and lk_target=0.
- Lookup, 0-cycle latency: lk_hit=lk_valid && a valid way in the set has a matching tag. At most one way may match; the update rule guarantees this.
- Bypass: if upd_valid, upd set == lk set and upd tag == lk tag in the same cycle, then lk_hit=1 and lk_target=upd_target, regardless of array contents.
- Update, takes effect at the next edge:
  - Tag matches a valid way in the set: overwrite that way's target.
  - Else, an invalid way exists: allocate the lowest-numbered invalid way.
  - Else: allocate the PLRU victim way.
  - In every case, write tag, target and valid=1.
- PLRU: tree of WAYS-1 bits per set; bit 0 = root. Victim: follow bits (0=left/lower, 1=right). Touch: set the path bits to point away from the touched way.
  - A lookup hit touches its way.
  - An update touches the way written.
  - Same set, same cycle, both active: apply the lookup touch first, then the update touch (update wins on shared bits). Different sets: apply both.
- Flush: all valid=0 next edge; PLRU unchanged.
  - Flush with upd_valid in the same cycle: flush wins; the written entry ends invalid, but its tag/target storage is still written.
  - Lookups in the flush cycle use pre-flush state.
- rst asserted mid-operation overrides flush and update in that cycle.
- lk_valid=0: no PLRU touch, lk_hit=0.

Optional Feature:
- Macro BTB_ASSOC_STATS_EN.
- Defined: adds outputs stat_lookups, stat_hits, stat_evictions, each 32-bit.
  - stat_lookups increments on lk_valid.
  - stat_hits increments on lk_hit.
  - stat_evictions increments when an update replaces a valid, non-matching way.
  - All reset to 0; wrap modulo 2**32; flush does not clear them.
- Undefined: no such ports or logic.

Decomposition:
- Package btb_pkg:
  - btb_entry_t struct {valid, tag, target}, sized via package params, or pass widths as module params if the team prefers.
  - Functions plru_victim(bits, WAYS) and plru_touch(bits, way, WAYS).
- Sub-module btb_plru: one instance per set.
  - Inputs: touch_a_en, touch_a_way, touch_b_en, touch_b_way.
  - Output: victim way.
  - Holds the per-set PLRU register and owns the ordering rule.

Test Plan:
- Reset, then lookup pc=0x100 -> lk_hit=0, lk_target=0.
- Update pc=0x100 target=0x400; next cycle lookup 0x100 -> hit, target 0x400. Lookup 0x104 -> miss.
- Same-cycle update pc=0x200 target=0x800 with lookup pc=0x200 -> hit, target 0x800 via bypass. Next cycle same result from the array.
- WAYS=2, IDX_W=3: updates 0x100, 0x120, then lookup 0x100, then update 0x140 (same set) -> 0x120 evicted. 0x100 and 0x140 hit; 0x120 misses. With stats, stat_evictions=1.
- Update 0x100 target 0x400, then update 0x100 target 0x500 -> no second way used: lookup returns 0x500; a later 0x120 fill takes the invalid way, not an eviction.
- Fill entries, assert flush with a concurrent update -> all lookups miss next cycle. Assert rst during an update -> entry not written; PLRU zeroed.
